// File: rtl/uart_rx_packer_if.sv
// Packet handshake between the UART receiver/packer and its downstream consumer.
// DATA_W must equal WORDS_PER_PACKET*BITS_PER_WORD of the attached packer.
interface uart_rx_packer_if #(
  parameter int unsigned DATA_W = 48
) ();
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_packer.sv
// UART receiver that packs WORDS_PER_PACKET words into one double-buffered output packet.
// The next packet accumulates while the current one waits for the consumer.
module uart_rx_packer #(
  parameter int unsigned CLOCKS_PER_PULSE = 434,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned WORDS_PER_PACKET = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  uart_rx_packer_if.master pkt,
  output logic             frame_err,
  output logic             overflow
);

  localparam int unsigned PacketW = WORDS_PER_PACKET * BITS_PER_WORD;
  localparam int unsigned CntW    = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int unsigned BitW    = $clog2(BITS_PER_WORD + 1);
  localparam int unsigned IdxW    = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;
  localparam int unsigned HalfCnt = (CLOCKS_PER_PULSE / 2 > 0) ? CLOCKS_PER_PULSE / 2 - 1 : 0;

  localparam logic [CntW-1:0] HalfLast = CntW'(HalfCnt);
  localparam logic [CntW-1:0] FullLast = CntW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(BITS_PER_WORD - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(WORDS_PER_PACKET - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                   state_q, state_d;
  logic                     rx_meta_q, rx_sync_q;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [BitW-1:0]          bit_q, bit_d;
  logic [BITS_PER_WORD-1:0] shift_q, shift_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [PacketW-1:0]       acc_q, acc_d;
  logic [PacketW-1:0]       data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     fe_q, fe_d;
  logic                     ov_q, ov_d;
  logic                     word_ok;
  logic [PacketW-1:0]       packet_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    fe_d    = 1'b0;
    word_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_sync_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[BITS_PER_WORD-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BitLast) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == FullLast) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            word_ok = 1'b1;
            state_d = StIdle;
          end else begin
            fe_d    = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Packet path: the accepted word lands in its slot, and on the last slot the whole
  // packet moves to the output register if it is free or being drained this cycle.
  always_comb begin
    packet_full = acc_q;
    packet_full[idx_q*BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    ov_d    = 1'b0;
    if (valid_q && pkt.m_ready) valid_d = 1'b0;
    if (word_ok) begin
      acc_d = packet_full;
      if (idx_q == IdxLast) begin
        idx_d = '0;
        if (!valid_q || pkt.m_ready) begin
          data_d  = packet_full;
          valid_d = 1'b1;
        end else begin
          ov_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  assign pkt.m_data  = data_q;
  assign pkt.m_valid = valid_q;
  assign frame_err   = fe_q;
  assign overflow    = ov_q;

endmodule
